// File: rtl/aes128_inv_round_iter.sv
// Iterative AES-128 decryption core.
// Expands the cipher key once into 11 stored round keys. Each decrypt then
// runs the initial AddRoundKey and ten inverse rounds, one round per clock.
`timescale 1ns/1ps

module aes128_inv_round_iter #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         START,
  input  logic         NEW_KEY,
  input  logic [127:0] IN_DATA,
  input  logic [127:0] IN_KEY,
  output logic         BUSY,
  output logic         DONE,
  output logic         KEY_VALID,
  output logic [127:0] OUT_DATA
);

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes128_inv_round_iter: only NUM_ROUNDS = 10 is supported");
  end

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_KEYEXP = 2'd1;
  localparam logic [1:0] S_INIT   = 2'd2;
  localparam logic [1:0] S_ROUND  = 2'd3;

  // Byte x of a table sits at bits [2047-8x -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  // Multiply by 02 in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One InvMixColumns column; 09/0b/0d/0e built from a single xtime chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Next round key from the previous one (RotWord, SubWord, Rcon, XOR chain).
  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {fwd_sbox(k[23:16]), fwd_sbox(k[15:8]), fwd_sbox(k[7:0]), fwd_sbox(k[31:24])}
         ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [1:0]   r_fsm;
  logic [3:0]   r_cnt;
  logic [127:0] r_data;
  logic [127:0] r_out;
  logic         r_done;
  logic         r_key_valid;
  logic [127:0] r_rk [11];

  logic [127:0] w_shift;
  logic [127:0] w_sub;
  logic [127:0] w_ark;
  logic [127:0] w_mix;
  logic [127:0] w_round;
  logic [127:0] w_rk_sel;
  logic [127:0] w_kexp;
  logic         w_accept;
  logic         w_load_key;

  assign w_accept   = (r_fsm == S_IDLE) && START;
  assign w_load_key = NEW_KEY || !r_key_valid;
  assign w_rk_sel   = r_rk[r_cnt];
  assign w_kexp     = key_expand(r_rk[r_cnt - 4'd1], rcon(r_cnt));

  // Inverse round datapath: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_shift = '0;
    w_sub   = '0;
    w_mix   = '0;
    // Row r rotates right by r: dest (r,c) takes source (r, c-r mod 4).
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_shift[127-8*(r+4*c) -: 8] = r_data[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    for (int b = 0; b < 16; b++) begin
      w_sub[127-8*b -: 8] = inv_sbox(w_shift[127-8*b -: 8]);
    end
    w_ark = w_sub ^ w_rk_sel;
    for (int c = 0; c < 4; c++) begin
      w_mix[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
    end
    // The last round (rk[0]) skips InvMixColumns.
    w_round = (r_cnt == 4'd0) ? w_ark : w_mix;
  end

  // Round-key storage: rk[0] loads on acceptance, rk[1..10] fill during KEYEXP.
  always_ff @(posedge clk) begin
    // NOTE: the key array has no reset; KEY_VALID alone says whether it can be trusted.
    if (!rst) begin
      if (w_accept && w_load_key) begin
        r_rk[0] <= IN_KEY;
      end else if (r_fsm == S_KEYEXP) begin
        r_rk[r_cnt] <= w_kexp;
      end
    end
  end

  // Control FSM, round counter, state register and result register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      r_fsm       <= S_IDLE;
      r_cnt       <= 4'd0;
      r_out       <= '0;
      r_done      <= 1'b0;
      r_key_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          if (START) begin
            r_data <= IN_DATA;
            if (w_load_key) begin
              r_key_valid <= 1'b0;
              r_cnt       <= 4'd1;
              r_fsm       <= S_KEYEXP;
            end else begin
              r_fsm <= S_INIT;
            end
          end
        end
        S_KEYEXP: begin
          if (r_cnt == 4'd10) begin
            r_key_valid <= 1'b1;
            r_fsm       <= S_INIT;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_INIT: begin
          r_data <= r_data ^ r_rk[10];
          r_cnt  <= 4'd9;
          r_fsm  <= S_ROUND;
        end
        default: begin
          r_data <= w_round;
          if (r_cnt == 4'd0) begin
            r_out  <= w_round;
            r_done <= 1'b1;
            r_fsm  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
      endcase
    end
  end

  assign BUSY      = (r_fsm != S_IDLE);
  assign DONE      = r_done;
  assign KEY_VALID = r_key_valid;
  assign OUT_DATA  = r_out;

endmodule

// File: tb/tb_aes128_inv_round_iter.sv
// Self-checking bench for aes128_inv_round_iter: FIPS-197 vectors, key reuse,
// START-while-busy, mid-run reset and random vectors against a byte-level model.
`timescale 1ns/1ps

module tb_aes128_inv_round_iter;

  logic         clk;
  logic         rst;
  logic         START;
  logic         NEW_KEY;
  logic [127:0] IN_DATA;
  logic [127:0] IN_KEY;
  logic         BUSY;
  logic         DONE;
  logic         KEY_VALID;
  logic [127:0] OUT_DATA;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;

  aes128_inv_round_iter #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .START     (START),
    .NEW_KEY   (NEW_KEY),
    .IN_DATA   (IN_DATA),
    .IN_KEY    (IN_KEY),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .KEY_VALID (KEY_VALID),
    .OUT_DATA  (OUT_DATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (GF arithmetic, byte arrays) ----------------
  logic [7:0] sbox_t [256];
  logic [7:0] inv_t  [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from multiplicative inverse plus affine map; inverse table by inversion.
  task automatic build_tables;
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_t[x] = s;
      inv_t[s]  = 8'(x);
    end
  endtask

  function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input logic [127:0] key);
    logic [31:0] w [44];
    logic [7:0]  st [16];
    logic [7:0]  tmp [16];
    logic [7:0]  rc;
    logic [31:0] tw;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {tw[23:0], tw[31:24]};
        tw = {sbox_t[tw[31:24]], sbox_t[tw[23:16]], sbox_t[tw[15:8]], sbox_t[tw[7:0]]};
        tw[31:24] = tw[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int k = 0; k < 16; k++) st[k] = ct[127-8*k -: 8] ^ w[40 + k/4][31-8*(k%4) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          tmp[r+4*c] = st[r+4*((c-r+4)%4)];
      for (int k = 0; k < 16; k++) st[k] = inv_t[tmp[k]] ^ w[4*rnd + k/4][31-8*(k%4) -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            tmp[r+4*c] = gmul(8'h0e, st[(r)%4+4*c])   ^ gmul(8'h0b, st[(r+1)%4+4*c]) ^
                         gmul(8'h0d, st[(r+2)%4+4*c]) ^ gmul(8'h09, st[(r+3)%4+4*c]);
        for (int k = 0; k < 16; k++) st[k] = tmp[k];
      end
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = st[k];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then scramble the inputs.
  task automatic launch(input logic [127:0] ct, input logic [127:0] key, input logic nk);
    IN_DATA = ct;
    IN_KEY  = key;
    NEW_KEY = nk;
    START   = 1'b1;
    tick();
    START   = 1'b0;
    IN_DATA = rand128();
    IN_KEY  = rand128();
    NEW_KEY = 1'($urandom_range(0, 1));
  endtask

  // Returns at the sample point of the first DONE cycle (lat = -1 on timeout).
  task automatic wait_done(output logic [127:0] out, output int lat, output logic [63:0] kv);
    lat = -1;
    out = '0;
    kv  = '0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      kv[i] = KEY_VALID;
      if (DONE) begin
        lat = i;
        out = OUT_DATA;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [127:0] ct, input logic [127:0] key, input logic nk,
                        output logic [127:0] out, output int lat, output logic [63:0] kv);
    launch(ct, key, nk);
    wait_done(out, lat, kv);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({BUSY, DONE, KEY_VALID, OUT_DATA} !== 131'd0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: busy=%b done=%b kv=%b out=%h, want all zero",
                 i, BUSY, DONE, KEY_VALID, OUT_DATA);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({BUSY, DONE, KEY_VALID, OUT_DATA} !== 131'd0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: busy=%b done=%b kv=%b out=%h, want all zero",
                 i, BUSY, DONE, KEY_VALID, OUT_DATA);
      end
    end
  endtask

  task automatic test_fips_c1;
    logic [127:0] out;
    int           lat;
    logic [63:0]  kv;
    run_op(C1_CT, C1_KEY, 1'b1, out, lat, kv);
    n_tests++;
    if (lat !== 21) begin n_fail++; $display("FAIL c1_latency: got %0d, want 21", lat); end
    n_tests++;
    if (out !== C1_PT) begin n_fail++; $display("FAIL c1_plaintext: got %h, want %h", out, C1_PT); end
    n_tests++;
    if (dut.r_rk[10] !== C1_RK10) begin
      n_fail++; $display("FAIL c1_rk10: got %h, want %h", dut.r_rk[10], C1_RK10);
    end
  endtask

  task automatic test_fips_b;
    logic [127:0] out;
    int           lat;
    logic [63:0]  kv;
    run_op(B_CT, B_KEY, 1'b1, out, lat, kv);
    n_tests++;
    if (out !== B_PT) begin n_fail++; $display("FAIL b_plaintext: got %h, want %h", out, B_PT); end
    n_tests++;
    if (lat !== 21) begin n_fail++; $display("FAIL b_latency: got %0d, want 21", lat); end
    n_tests++;
    if (kv[10:9] !== 2'b10) begin
      n_fail++; $display("FAIL b_key_valid_e9_e10: got e9=%b e10=%b, want e9=0 e10=1", kv[9], kv[10]);
    end
  endtask

  task automatic test_key_reuse;
    logic [127:0] out;
    logic [127:0] exp_c1_under_b;
    int           lat;
    logic [63:0]  kv;
    run_op(B_CT, rand128(), 1'b0, out, lat, kv);
    n_tests++;
    if (lat !== 11) begin n_fail++; $display("FAIL reuse_latency: got %0d, want 11", lat); end
    n_tests++;
    if (out !== B_PT) begin n_fail++; $display("FAIL reuse_plaintext: got %h, want %h", out, B_PT); end
    // We are at the DONE cycle now: a new START here must be accepted.
    exp_c1_under_b = model_decrypt(C1_CT, B_KEY);
    launch(C1_CT, C1_KEY, 1'b0);
    n_tests++;
    if (BUSY !== 1'b1) begin n_fail++; $display("FAIL done_cycle_accept_busy: got %b, want 1", BUSY); end
    wait_done(out, lat, kv);
    n_tests++;
    if (lat !== 11) begin n_fail++; $display("FAIL done_cycle_latency: got %0d, want 11", lat); end
    n_tests++;
    if (out !== exp_c1_under_b) begin
      n_fail++; $display("FAIL done_cycle_plaintext: got %h, want %h", out, exp_c1_under_b);
    end
  endtask

  task automatic test_busy_ignore;
    int           ndone;
    int           lat;
    logic [127:0] out;
    ndone = 0;
    lat   = -1;
    out   = '0;
    launch(C1_CT, C1_KEY, 1'b1);
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (DONE) begin
        ndone++;
        if (lat < 0) begin lat = i; out = OUT_DATA; end
      end
      if (i >= 3 && i <= 18 && (i % 3) == 0) begin
        START   = 1'b1;
        IN_DATA = rand128();
        IN_KEY  = rand128();
        NEW_KEY = 1'($urandom_range(0, 1));
      end else begin
        START = 1'b0;
      end
    end
    n_tests++;
    if (ndone !== 1) begin n_fail++; $display("FAIL busy_done_count: got %0d, want 1", ndone); end
    n_tests++;
    if (lat !== 21) begin n_fail++; $display("FAIL busy_latency: got %0d, want 21", lat); end
    n_tests++;
    if (out !== C1_PT) begin n_fail++; $display("FAIL busy_plaintext: got %h, want %h", out, C1_PT); end
  endtask

  task automatic test_reset_mid;
    int           ndone;
    int           lat;
    logic [127:0] out;
    logic [63:0]  kv;
    ndone = 0;
    launch(C1_CT, C1_KEY, 1'b1);
    for (int i = 1; i <= 14; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({BUSY, DONE, KEY_VALID, OUT_DATA} !== 131'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: busy=%b done=%b kv=%b out=%h, want all zero",
               BUSY, DONE, KEY_VALID, OUT_DATA);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (DONE) ndone++;
    end
    n_tests++;
    if (ndone !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses, want 0", ndone); end
    // KEY_VALID is 0, so NEW_KEY=0 must still take the expansion path.
    run_op(C1_CT, C1_KEY, 1'b0, out, lat, kv);
    n_tests++;
    if (lat !== 21) begin n_fail++; $display("FAIL midrst_relaunch_latency: got %0d, want 21", lat); end
    n_tests++;
    if (out !== C1_PT) begin
      n_fail++; $display("FAIL midrst_relaunch_plaintext: got %h, want %h", out, C1_PT);
    end
  endtask

  task automatic test_random;
    logic [127:0] stored_key;
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] exp;
    logic [127:0] out;
    logic         nk;
    int           exp_lat;
    int           lat;
    logic [63:0]  kv;
    stored_key = C1_KEY;
    for (int i = 0; i < 6; i++) begin
      nk  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      key = rand128();
      ct  = rand128();
      if (nk) stored_key = key;
      exp     = model_decrypt(ct, stored_key);
      exp_lat = nk ? 21 : 11;
      run_op(ct, key, nk, out, lat, kv);
      n_tests++;
      if (lat !== exp_lat) begin
        n_fail++; $display("FAIL rand[%0d]_latency: got %0d, want %0d", i, lat, exp_lat);
      end
      n_tests++;
      if (out !== exp) begin
        n_fail++; $display("FAIL rand[%0d]_plaintext: got %h, want %h", i, out, exp);
      end
      tick();
    end
  endtask

  initial begin
    rst     = 1'b1;
    START   = 1'b0;
    NEW_KEY = 1'b0;
    IN_DATA = '0;
    IN_KEY  = '0;
    build_tables();
    test_reset();
    test_fips_c1();
    tick();
    test_fips_b();
    tick();
    test_key_reuse();
    tick();
    test_busy_ignore();
    test_reset_mid();
    tick();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
